n64_mem_arbiter: RTL and testbench

//  Shares the single cart memory port (SDRAM/flash controller) among NUM_REQ requesters: PI front-end, SI/EEPROM, CPU/USB.

---
 rtl/n64_arb_pkg.sv | 22 ++
 rtl/n64_rr_arbiter.sv | 32 +++
 rtl/n64_mem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_n64_mem_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/n64_arb_pkg.sv
// Shared types and widths for the cart memory-port arbiter.
// The optional ack watchdog in n64_mem_arbiter is enabled by N64_ARB_TIMEOUT_EN.
package n64_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_REQUEST  = 2'd1,
    ARB_WAIT_ACK = 2'd2
  } arb_state_e;

  localparam int unsigned N64_BANK_W = 4;
  localparam int unsigned N64_ADDR_W = 26;
  localparam int unsigned N64_DATA_W = 32;

  localparam logic [N64_DATA_W-1:0] N64_TIMEOUT_FILL = 32'hFFFF_FFFF;

  // Round-robin successor of a requester index.
  function automatic int unsigned n64_next_ptr(input int unsigned idx, input int unsigned num);
    return (idx + 1 >= num) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/n64_rr_arbiter.sv
// Combinational round-robin pick: first requesting index at or after ptr, wrapping.
module n64_rr_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [PTR_W-1:0]   grant,
  output logic               valid
);

  int               idx;
  logic [PTR_W-1:0] idx_w;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    idx_w = '0;
    for (int off = int'(NUM_REQ) - 1; off >= 0; off--) begin
      idx = int'(ptr) + off;
      if (idx >= int'(NUM_REQ)) idx = idx - int'(NUM_REQ);
      idx_w = idx[PTR_W-1:0];
      if (req[idx_w]) begin
        grant = idx_w;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/n64_mem_arbiter.sv
// Round-robin arbiter sharing one cart memory port, one transaction in flight.
// Define N64_ARB_TIMEOUT_EN to add the ack watchdog (TIMEOUT_CYCLES).
module n64_mem_arbiter
  import n64_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ-1:0]       i_write,
  input  logic [NUM_REQ*4-1:0]     i_bank,
  input  logic [NUM_REQ*26-1:0]    i_address,
  input  logic [NUM_REQ*32-1:0]    i_wdata,
  output logic [NUM_REQ-1:0]       o_busy,
  output logic [NUM_REQ-1:0]       o_ack,
  output logic [31:0]              o_rdata,
  output logic                     o_mem_request,
  output logic                     o_mem_write,
  input  logic                     i_mem_busy,
  input  logic                     i_mem_ack,
  output logic [3:0]               o_mem_bank,
  output logic [25:0]              o_mem_address,
  output logic [31:0]              o_mem_wdata,
  input  logic [31:0]              i_mem_rdata,
  output logic                     o_timeout
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  arb_state_e             state_q, state_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [PTR_W-1:0]       owner_q, owner_d;
  logic                   write_q, write_d;
  logic [N64_BANK_W-1:0]  bank_q, bank_d;
  logic [N64_ADDR_W-1:0]  addr_q, addr_d;
  logic [N64_DATA_W-1:0]  wdata_q, wdata_d;
  logic [N64_DATA_W-1:0]  rdata_q, rdata_d;
  logic [NUM_REQ-1:0]     ack_q, ack_d;
  logic [PTR_W-1:0]       pick_grant;
  logic                   pick_valid;

  n64_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req   (i_req),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .valid (pick_valid)
  );

`ifdef N64_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W =
      ($clog2(TIMEOUT_CYCLES + 1) > 10) ? $clog2(TIMEOUT_CYCLES + 1) : 10;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      o_busy[i] = i_req[i] &&
                  !(state_q == ARB_IDLE && pick_valid && pick_grant == PTR_W'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    write_d = write_q;
    bank_d  = bank_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ack_d   = '0;
`ifdef N64_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          owner_d = pick_grant;
          ptr_d   = PTR_W'(n64_next_ptr(int'(pick_grant), NUM_REQ));
          write_d = i_write[pick_grant];
          bank_d  = i_bank[pick_grant*N64_BANK_W +: N64_BANK_W];
          addr_d  = i_address[pick_grant*N64_ADDR_W +: N64_ADDR_W];
          wdata_d = i_wdata[pick_grant*N64_DATA_W +: N64_DATA_W];
          state_d = ARB_REQUEST;
        end
      end
      ARB_REQUEST: begin
        if (!i_mem_busy) begin
          if (i_mem_ack) begin
            ack_d[owner_q] = 1'b1;
            if (!write_q) rdata_d = i_mem_rdata;
            state_d = ARB_IDLE;
          end else begin
            state_d = ARB_WAIT_ACK;
`ifdef N64_ARB_TIMEOUT_EN
            cnt_d = '0;
`endif
          end
        end
      end
      ARB_WAIT_ACK: begin
        if (i_mem_ack) begin
          ack_d[owner_q] = 1'b1;
          if (!write_q) rdata_d = i_mem_rdata;
          state_d = ARB_IDLE;
        end
`ifdef N64_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // Abort so a dead controller cannot lock out every requester.
          ack_d[owner_q] = 1'b1;
          rdata_d        = N64_TIMEOUT_FILL;
          timeout_d      = 1'b1;
          state_d        = ARB_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      write_q <= 1'b0;
      bank_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= '0;
`ifdef N64_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      write_q <= write_d;
      bank_q  <= bank_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
`ifdef N64_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign o_mem_request = (state_q == ARB_REQUEST);
  assign o_mem_write   = write_q;
  assign o_mem_bank    = bank_q;
  assign o_mem_address = addr_q;
  assign o_mem_wdata   = wdata_q;
  assign o_rdata       = rdata_q;
  assign o_ack         = ack_q;
`ifdef N64_ARB_TIMEOUT_EN
  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_n64_mem_arbiter.sv
// Self-checking bench for n64_mem_arbiter: directed scenarios plus a randomized
// run against a transaction-level model (pending set, rr pointer, one in flight).
module tb_n64_mem_arbiter;

  localparam int N = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req, wr;
  logic [N*4-1:0]  bank;
  logic [N*26-1:0] addr;
  logic [N*32-1:0] wdata;
  logic [N-1:0]  busy, ack;
  logic [31:0]   rdata;
  logic          mem_req, mem_wr, mem_busy, mem_ack, timeout;
  logic [3:0]    mem_bank;
  logic [25:0]   mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  n64_mem_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_req         (req),
    .i_write       (wr),
    .i_bank        (bank),
    .i_address     (addr),
    .i_wdata       (wdata),
    .o_busy        (busy),
    .o_ack         (ack),
    .o_rdata       (rdata),
    .o_mem_request (mem_req),
    .o_mem_write   (mem_wr),
    .i_mem_busy    (mem_busy),
    .i_mem_ack     (mem_ack),
    .o_mem_bank    (mem_bank),
    .o_mem_address (mem_addr),
    .o_mem_wdata   (mem_wdata),
    .i_mem_rdata   (mem_rdata),
    .o_timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    req = '0; wr = '0; bank = '0; addr = '0; wdata = '0;
    mem_busy = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic int rr_pick(input logic [N-1:0] p, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (p[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    clear_inputs();
    req = 3'b111; wr = 3'b111; addr = '1; wdata = '1; bank = '1;
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    tick();
    checks++;
    if ({mem_req, mem_wr, ack, timeout} !== 6'b0)
      begin errors++; $display("FAIL reset_ctrl got %b want 000000", {mem_req, mem_wr, ack, timeout}); end
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
    checks++;
    if ({mem_bank, mem_addr, mem_wdata} !== 62'h0)
      begin errors++; $display("FAIL reset_latches got %h want 0", {mem_bank, mem_addr, mem_wdata}); end
    // Pointer at 0 after reset: requester 0 is the one not busy.
    checks++;
    if (busy !== 3'b110) begin errors++; $display("FAIL reset_busy got %b want 110", busy); end
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_single_read;
    do_reset();
    req = 3'b001; addr[25:0] = 26'h0001000;
    #1;
    checks++;
    if (busy !== 3'b000) begin errors++; $display("FAIL read_accept got %b want 000", busy); end
    tick();
    req = '0;
    checks++;
    if ({mem_req, mem_wr, mem_addr} !== {1'b1, 1'b0, 26'h0001000})
      begin errors++; $display("FAIL read_issue got %b %b %h want 1 0 0001000", mem_req, mem_wr, mem_addr); end
    tick();
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL read_drop got %b want 0", mem_req); end
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ack = 1'b0;
    checks++;
    if ({ack, rdata} !== {3'b001, 32'hDEADBEEF})
      begin errors++; $display("FAIL read_ack got %b %h want 001 deadbeef", ack, rdata); end
    tick();
    checks++;
    if ({ack, rdata} !== {3'b000, 32'hDEADBEEF})
      begin errors++; $display("FAIL read_ack_once got %b %h want 000 deadbeef", ack, rdata); end
  endtask

  task automatic test_round_robin;
    int n = 0;
    rst = 1'b1;
    clear_inputs();
    req = 3'b111;
    for (int i = 0; i < N; i++) addr[i*26 +: 26] = 26'h100 + 26'(i);
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 60 && n < 6; c++) begin
      tick();
      mem_ack = 1'b0;
      checks++;
      if (ack !== 3'b000 && mem_req)
        begin errors++; $display("FAIL rr_overlap got ack %b req %b want no overlap", ack, mem_req); end
      if (mem_req) begin
        checks++;
        if (mem_addr !== 26'h100 + 26'(n % 3))
          begin errors++; $display("FAIL rr_order got %h want %h", mem_addr, 26'h100 + 26'(n % 3)); end
        n++;
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_CAFE;
        if (n == 6) req = '0;
      end
    end
    checks++;
    if (n != 6) begin errors++; $display("FAIL rr_count got %0d want 6", n); end
    tick();
    mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_mem_busy;
    logic [31:0] prev;
    int extra = 0;
    prev = rdata;
    req = 3'b001; wr = 3'b001; bank[3:0] = 4'h5; addr[25:0] = 26'h2ABCDEF; wdata[31:0] = 32'hA5A5_5A5A;
    tick();
    req = '0; bank = '0; addr = '0; wdata = '0;
    mem_busy = 1'b1;
    for (int j = 0; j < 5; j++) begin
      checks++;
      if ({mem_req, mem_wr, mem_bank, mem_addr, mem_wdata} !==
          {1'b1, 1'b1, 4'h5, 26'h2ABCDEF, 32'hA5A5_5A5A})
        begin errors++; $display("FAIL busy_hold cyc %0d got %b %h %h want 1 2abcdef a5a55a5a", j, mem_req, mem_addr, mem_wdata); end
      tick();
    end
    checks++;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL busy_release got %b want 1", mem_req); end
    mem_busy = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    tick();
    mem_ack = 1'b0;
    checks++;
    if ({ack, mem_req, rdata} !== {3'b001, 1'b0, prev})
      begin errors++; $display("FAIL busy_ack got %b %b %h want 001 0 %h", ack, mem_req, rdata, prev); end
    for (int j = 0; j < 5; j++) begin
      tick();
      if (mem_req || ack !== 3'b000) extra++;
    end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL busy_single got %0d extra cycles want 0", extra); end
  endtask

  task automatic test_write_same_cycle;
    logic [31:0] prev;
    prev = rdata;
    wr = 3'b010; req = 3'b010; wdata[63:32] = 32'h12345678; addr[51:26] = 26'h0000ABC;
    tick();
    req = '0;
    checks++;
    if ({mem_req, mem_wr, mem_wdata, mem_addr} !== {1'b1, 1'b1, 32'h12345678, 26'h0000ABC})
      begin errors++; $display("FAIL wr_issue got %b %b %h %h want 1 1 12345678 0000abc", mem_req, mem_wr, mem_wdata, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_ack = 1'b0;
    checks++;
    if ({ack, rdata} !== {3'b010, prev})
      begin errors++; $display("FAIL wr_ack got %b %h want 010 %h", ack, rdata, prev); end
    tick();
    checks++;
    if (ack !== 3'b000) begin errors++; $display("FAIL wr_ack_once got %b want 000", ack); end
    clear_inputs();
  endtask

  task automatic test_reset_mid;
    req = 3'b001; addr[25:0] = 26'h77;
    tick();
    req = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    tick();
    mem_ack = 1'b0;
    checks++;
    if ({ack, mem_req, mem_wr, timeout} !== 6'b0)
      begin errors++; $display("FAIL rstmid_ctrl got %b want 000000", {ack, mem_req, mem_wr, timeout}); end
    checks++;
    if ({rdata, mem_bank, mem_addr, mem_wdata} !== 94'h0)
      begin errors++; $display("FAIL rstmid_data got %h %h want 0 0", rdata, mem_addr); end
    req = 3'b011; addr[25:0] = 26'h40; addr[51:26] = 26'h80;
    #1;
    checks++;
    if (busy !== 3'b010) begin errors++; $display("FAIL rstmid_ptr got %b want 010", busy); end
    tick();
    req = 3'b010;
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 26'h40})
      begin errors++; $display("FAIL rstmid_first got %b %h want 1 40", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'h2222_2222;
    tick();
    mem_ack = 1'b0;
    checks++;
    if ({ack, rdata} !== {3'b001, 32'h2222_2222})
      begin errors++; $display("FAIL rstmid_ack got %b %h want 001 22222222", ack, rdata); end
    tick();
    req = '0;
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 26'h80})
      begin errors++; $display("FAIL rstmid_second got %b %h want 1 80", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'h3333_3333;
    tick();
    mem_ack = 1'b0;
    checks++;
    if ({ack, rdata} !== {3'b010, 32'h3333_3333})
      begin errors++; $display("FAIL rstmid_ack2 got %b %h want 010 33333333", ack, rdata); end
    tick();
  endtask

  task automatic test_timeout;
    int bad = 0;
    do_reset();
    req = 3'b010;
    tick();
    req = '0;
    tick();
`ifdef N64_ARB_TIMEOUT_EN
    // Watchdog fires 16 cycles after the first WAIT_ACK cycle.
    for (int j = 0; j < 16; j++) begin
      if (timeout || ack !== 3'b000) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL to_early got %0d early cycles want 0", bad); end
    checks++;
    if ({timeout, ack, rdata} !== {1'b1, 3'b010, 32'hFFFF_FFFF})
      begin errors++; $display("FAIL to_fire got %b %b %h want 1 010 ffffffff", timeout, ack, rdata); end
    tick();
    checks++;
    if ({timeout, ack} !== 4'b0) begin errors++; $display("FAIL to_pulse got %b %b want 0 000", timeout, ack); end
`else
    for (int j = 0; j < 40; j++) begin
      if (timeout || ack !== 3'b000 || mem_req) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL to_disabled got %0d bad cycles want 0", bad); end
`endif
    do_reset();
  endtask

  task automatic test_random;
    logic [N-1:0] pend, eack, ebusy;
    logic [25:0]  fa[N];
    logic [31:0]  fd[N];
    logic [3:0]   fb[N];
    logic         fw[N];
    logic [25:0]  ta;
    logic [31:0]  td, erd;
    logic [3:0]   tbk;
    logic         tw, mb, ma;
    int           mptr, ost, own, cd, g;
    do_reset();
    pend = '0; eack = '0; erd = '0; mptr = 0; ost = 0; own = 0; cd = 0;
    ta = '0; td = '0; tbk = '0; tw = 1'b0;
    for (int i = 0; i < N; i++) begin fa[i] = '0; fd[i] = '0; fb[i] = '0; fw[i] = 1'b0; end
    for (int cyc = 0; cyc < 600; cyc++) begin
      checks++;
      if ({ack, rdata} !== {eack, erd})
        begin errors++; $display("FAIL rnd_ack cyc %0d got %b %h want %b %h", cyc, ack, rdata, eack, erd); end
      checks++;
      if (mem_req !== (ost == 1))
        begin errors++; $display("FAIL rnd_memreq cyc %0d got %b want %b", cyc, mem_req, ost == 1); end
      if (ost == 1) begin
        checks++;
        if ({mem_wr, mem_bank, mem_addr, mem_wdata} !== {tw, tbk, ta, td})
          begin errors++; $display("FAIL rnd_fields cyc %0d got %h %h want %h %h", cyc, mem_addr, mem_wdata, ta, td); end
      end
      for (int i = 0; i < N; i++) begin
        if (pend[i] && $urandom_range(0, 19) == 0) pend[i] = 1'b0;
        else if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          fa[i] = 26'($urandom); fd[i] = $urandom; fb[i] = 4'($urandom); fw[i] = 1'($urandom);
        end
        wr[i] = fw[i];
        bank[i*4 +: 4] = fb[i];
        addr[i*26 +: 26] = fa[i];
        wdata[i*32 +: 32] = fd[i];
      end
      req = pend;
      mb = 1'b0; ma = 1'b0;
      if (ost == 1) begin
        mb = ($urandom_range(0, 2) == 0);
        if (!mb) ma = 1'($urandom);
      end else if (ost == 2) ma = (cd == 0);
      else ma = ($urandom_range(0, 3) == 0);
      mem_busy = mb; mem_ack = ma; mem_rdata = $urandom;
      #1;
      g = (ost == 0) ? rr_pick(pend, mptr) : -1;
      ebusy = pend;
      if (g >= 0) ebusy[g] = 1'b0;
      checks++;
      if (busy !== ebusy)
        begin errors++; $display("FAIL rnd_busy cyc %0d got %b want %b", cyc, busy, ebusy); end
      eack = '0;
      if (g >= 0) begin
        own = g; ta = fa[g]; td = fd[g]; tbk = fb[g]; tw = fw[g];
        pend[g] = 1'b0; mptr = (g + 1) % N; ost = 1;
      end else if ((ost == 1 && !mb && ma) || (ost == 2 && ma)) begin
        eack[own] = 1'b1;
        if (!tw) erd = mem_rdata;
        ost = 0;
      end else if (ost == 1 && !mb) begin
        ost = 2; cd = $urandom_range(0, 4);
      end else if (ost == 2) cd--;
      tick();
    end
    do_reset();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_mem_busy();
    test_write_same_cycle();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
